// File: rtl/fifo_parity_checker.sv
// Pops FIFO words, checks parity in the MSB, strips it and forwards payload via a 2-entry buffer.
// 1-cycle latency; in_grant_out is registered and drops only when the buffer will be full.
module fifo_parity_checker #(
  parameter int DATA_WIDTH    = 17,
  parameter int PARITY_ODD    = 0,
  parameter int DROP_ON_ERR   = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_in,
  output logic                     in_grant_out,
  input  logic [DATA_WIDTH-1:0]    in_data_in,
  output logic                     out_valid_out,
  input  logic                     out_grant_in,
  output logic [DATA_WIDTH-2:0]    out_data_out,
  output logic                     out_err_out,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_out,
  output logic                     err_sticky_out,
  input  logic                     err_clr_in
);
  localparam int   PW       = DATA_WIDTH - 1;
  localparam logic PAR_ODD  = (PARITY_ODD != 0);
  localparam logic DROP     = (DROP_ON_ERR != 0);

  logic [1:0]               cnt_q, cnt_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            data_q [2];
  logic [PW-1:0]            data_d [2];
  logic [1:0]               err_q, err_d;
  logic                     grant_q, grant_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     sticky_q, sticky_d;
  logic                     par_err, in_fire, push, pop;

  always_comb begin
    par_err  = (^in_data_in) != PAR_ODD;
    in_fire  = in_valid_in & grant_q;
    push     = in_fire & ~(DROP & par_err);
    pop      = (cnt_q != 2'd0) & out_grant_in;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (push) begin
      data_d[wr_ptr_q] = in_data_in[PW-1:0];
      err_d[wr_ptr_q]  = par_err;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    // Grant is looked ahead from next occupancy so it never depends on out_grant_in combinationally.
    grant_d = (cnt_d < 2'd2);

    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    if (in_fire & par_err) begin
      sticky_d = 1'b1;
      if (err_clr_in) begin
        err_cnt_d = ERR_CNT_WIDTH'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end else if (err_clr_in) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      err_q     <= '0;
      grant_q   <= 1'b0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign in_grant_out   = grant_q;
  assign out_valid_out  = (cnt_q != 2'd0);
  assign out_data_out   = data_q[rd_ptr_q];
  assign out_err_out    = err_q[rd_ptr_q] & ~DROP;
  assign err_cnt_out    = err_cnt_q;
  assign err_sticky_out = sticky_q;
endmodule

// File: tb/tb_fifo_parity_checker.sv
// Bench for fifo_parity_checker: forwarding instance (a) and drop/2-bit-counter instance (b) share stimulus.
module tb_fifo_parity_checker;
  localparam int DW = 17;
  localparam int PW = DW - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_grant, err_clr;
  logic [DW-1:0] in_data;

  logic          a_in_grant, a_out_valid, a_out_err, a_sticky;
  logic [PW-1:0] a_out_data;
  logic [7:0]    a_err_cnt;
  logic          b_in_grant, b_out_valid, b_out_err, b_sticky;
  logic [PW-1:0] b_out_data;
  logic [1:0]    b_err_cnt;

  logic          sel_b = 1'b0;
  logic          s_grant, s_out_valid, s_out_err;
  logic [PW-1:0] s_out_data;
  assign s_grant     = sel_b ? b_in_grant  : a_in_grant;
  assign s_out_valid = sel_b ? b_out_valid : a_out_valid;
  assign s_out_err   = sel_b ? b_out_err   : a_out_err;
  assign s_out_data  = sel_b ? b_out_data  : a_out_data;

  fifo_parity_checker dut_a (
    .clk(clk), .rst(rst),
    .in_valid_in(in_valid), .in_grant_out(a_in_grant), .in_data_in(in_data),
    .out_valid_out(a_out_valid), .out_grant_in(out_grant), .out_data_out(a_out_data),
    .out_err_out(a_out_err), .err_cnt_out(a_err_cnt), .err_sticky_out(a_sticky),
    .err_clr_in(err_clr)
  );

  fifo_parity_checker #(.DROP_ON_ERR(1), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid_in(in_valid), .in_grant_out(b_in_grant), .in_data_in(in_data),
    .out_valid_out(b_out_valid), .out_grant_in(out_grant), .out_data_out(b_out_data),
    .out_err_out(b_out_err), .err_cnt_out(b_err_cnt), .err_sticky_out(b_sticky),
    .err_clr_in(err_clr)
  );

  int          checks = 0;
  int          passed = 0;
  int          cyc    = 0;
  logic [PW:0] exp_q[$];
  int          stamp_q[$];

  // Even parity: a word is bad when the XOR of all its bits is 1.
  function automatic logic is_bad(input logic [DW-1:0] w);
    return ^w;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [PW-1:0] p, input logic bad);
    return {(^p) ^ bad, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_grant = 1'b0; err_clr = 1'b0;
    exp_q.delete();
    stamp_q.delete();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_grant = 1'b0; err_clr = 1'b1;
    step();
    step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_out_valid); else passed++;
    checks++; if (a_in_grant !== 1'b0) $display("FAIL reset_grant: got %b want 0", a_in_grant); else passed++;
    checks++; if (a_out_err !== 1'b0) $display("FAIL reset_err: got %b want 0", a_out_err); else passed++;
    checks++; if (a_err_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", a_err_cnt); else passed++;
    checks++; if (a_sticky !== 1'b0) $display("FAIL reset_sticky: got %b want 0", a_sticky); else passed++;
    checks++; if (a_out_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", a_out_data); else passed++;
    checks++; if (b_out_valid !== 1'b0 || b_in_grant !== 1'b0) $display("FAIL reset_b: valid=%b grant=%b want 0 0", b_out_valid, b_in_grant); else passed++;
    rst = 1'b0; err_clr = 1'b0;
    step();
    checks++; if (a_in_grant !== 1'b1 || b_in_grant !== 1'b1) $display("FAIL release_grant: a=%b b=%b want 1 1", a_in_grant, b_in_grant); else passed++;
  endtask

  task automatic test_good_stream();
    logic [DW-1:0] w[3];
    logic [PW:0]   e;
    int            sent, st;
    w[0] = 17'h10001; w[1] = 17'h00003; w[2] = 17'h1FFFE;
    sel_b = 1'b0;
    do_reset();
    out_grant = 1'b1;
    sent = 0;
    for (int c = 0; c < 20 && (sent < 3 || exp_q.size() != 0); c++) begin
      in_valid = (sent < 3);
      if (sent < 3) in_data = w[sent];
      if (s_out_valid && out_grant) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL good_extra: unexpected word %h", s_out_data);
        else begin
          e  = exp_q.pop_front();
          st = stamp_q.pop_front();
          if ({s_out_err, s_out_data} !== e || cyc != st + 1)
            $display("FAIL good_word: got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                     s_out_err, s_out_data, cyc, e[PW], e[PW-1:0], st + 1);
          else passed++;
        end
      end
      if (in_valid && s_grant) begin
        exp_q.push_back({is_bad(in_data), in_data[PW-1:0]});
        stamp_q.push_back(cyc);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (sent != 3 || exp_q.size() != 0) $display("FAIL good_drain: sent=%0d left=%0d want 3 0", sent, exp_q.size()); else passed++;
    checks++; if (a_err_cnt !== 8'd0) $display("FAIL good_cnt: got %0d want 0", a_err_cnt); else passed++;
  endtask

  task automatic test_err_forward();
    sel_b = 1'b0;
    do_reset();
    in_valid = 1'b1; in_data = 17'h00001; out_grant = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (a_err_cnt !== 8'd1) $display("FAIL fwd_cnt: got %0d want 1", a_err_cnt); else passed++;
    checks++; if (a_sticky !== 1'b1) $display("FAIL fwd_sticky: got %b want 1", a_sticky); else passed++;
    checks++;
    if ({a_out_valid, a_out_err, a_out_data} !== {1'b1, 1'b1, 16'h0001})
      $display("FAIL fwd_word: got v=%b err=%b data=%h want v=1 err=1 data=0001", a_out_valid, a_out_err, a_out_data);
    else passed++;
    out_grant = 1'b1;
    step();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL fwd_once: valid=%b want 0", a_out_valid); else passed++;
  endtask

  task automatic test_err_drop();
    logic [DW-1:0] w[2];
    logic [PW:0]   e;
    int            sent, seen;
    w[0] = 17'h00001; w[1] = 17'h10001;
    sel_b = 1'b1;
    do_reset();
    out_grant = 1'b1;
    sent = 0; seen = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (sent < 2);
      if (sent < 2) in_data = w[sent];
      if (s_out_valid && out_grant) begin
        seen++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL drop_extra: unexpected err=%b data=%h", s_out_err, s_out_data);
        else begin
          e = exp_q.pop_front();
          if ({s_out_err, s_out_data} !== e)
            $display("FAIL drop_word: got err=%b data=%h want err=%b data=%h", s_out_err, s_out_data, e[PW], e[PW-1:0]);
          else passed++;
        end
      end
      if (in_valid && s_grant) begin
        if (!is_bad(in_data)) exp_q.push_back({1'b0, in_data[PW-1:0]});
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (seen != 1 || exp_q.size() != 0) $display("FAIL drop_count: seen=%0d left=%0d want 1 0", seen, exp_q.size()); else passed++;
    checks++; if (b_err_cnt !== 2'd1) $display("FAIL drop_cnt: got %0d want 1", b_err_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[4];
    logic [PW:0]   e;
    int            sent;
    logic          first, chk_grant;
    for (int i = 0; i < 4; i++) w[i] = mk(PW'(16'h1234 + i * 16'h1111), 1'b0);
    sel_b = 1'b0;
    do_reset();
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (sent < 4);
      if (sent < 4) in_data = w[sent];
      if (in_valid && s_grant) begin
        exp_q.push_back({1'b0, in_data[PW-1:0]});
        sent++;
      end
      step();
      if (c == 2 || c == 5) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== w[0][PW-1:0])
          $display("FAIL bp_hold: c=%0d valid=%b data=%h want 1 %h", c, s_out_valid, s_out_data, w[0][PW-1:0]);
        else passed++;
      end
    end
    checks++; if (sent != 2) $display("FAIL bp_accepted: got %0d want 2", sent); else passed++;
    checks++; if (s_grant !== 1'b0) $display("FAIL bp_grant_low: got %b want 0", s_grant); else passed++;
    out_grant = 1'b1;
    first = 1'b1; chk_grant = 1'b0;
    for (int c = 0; c < 20 && (sent < 4 || exp_q.size() != 0); c++) begin
      if (chk_grant) begin
        checks++;
        if (s_grant !== 1'b1) $display("FAIL bp_grant_back: got %b want 1", s_grant); else passed++;
        chk_grant = 1'b0;
      end
      in_valid = (sent < 4);
      if (sent < 4) in_data = w[sent];
      if (s_out_valid && out_grant) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra: unexpected word %h", s_out_data);
        else begin
          e = exp_q.pop_front();
          if ({s_out_err, s_out_data} !== e)
            $display("FAIL bp_word: got err=%b data=%h want err=%b data=%h", s_out_err, s_out_data, e[PW], e[PW-1:0]);
          else passed++;
        end
        if (first) begin chk_grant = 1'b1; first = 1'b0; end
      end
      if (in_valid && s_grant) begin
        exp_q.push_back({1'b0, in_data[PW-1:0]});
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (sent != 4 || exp_q.size() != 0 || s_out_valid !== 1'b0) $display("FAIL bp_drain: sent=%0d left=%0d valid=%b want 4 0 0", sent, exp_q.size(), s_out_valid); else passed++;
  endtask

  task automatic test_saturation();
    sel_b = 1'b1;
    do_reset();
    out_grant = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = mk(PW'(i + 1), 1'b1);
      step();
      if (i == 1) begin
        checks++; if (b_err_cnt !== 2'd2) $display("FAIL sat_mid: got %0d want 2", b_err_cnt); else passed++;
      end
    end
    checks++; if (b_err_cnt !== 2'd3) $display("FAIL sat_cnt: got %0d want 3", b_err_cnt); else passed++;
    checks++; if (b_sticky !== 1'b1) $display("FAIL sat_sticky: got %b want 1", b_sticky); else passed++;
    err_clr = 1'b1;
    in_data = mk(16'h0077, 1'b1);
    step();
    checks++; if (b_err_cnt !== 2'd1 || b_sticky !== 1'b1) $display("FAIL clr_vs_err: cnt=%0d sticky=%b want 1 1", b_err_cnt, b_sticky); else passed++;
    in_valid = 1'b0;
    step();
    err_clr = 1'b0;
    checks++; if (b_err_cnt !== 2'd0 || b_sticky !== 1'b0) $display("FAIL clr_alone: cnt=%0d sticky=%b want 0 0", b_err_cnt, b_sticky); else passed++;
    checks++; if (b_out_valid !== 1'b0) $display("FAIL sat_no_output: valid=%b want 0", b_out_valid); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_stream();
    test_err_forward();
    test_err_drop();
    test_backpressure();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
